// File: rtl/morse_pkg.sv
// Shared types and the Morse code table for the morse_encoder slice.
// Digit support is compiled in with `define MORSE_DIGITS_EN.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam int NUM_LETTERS = 26;
    localparam int NUM_DIGITS  = 10;

`ifdef MORSE_DIGITS_EN
    localparam int PAT_W = 5;
`else
    localparam int PAT_W = 4;
`endif

    // Entry = {len[2:0], pattern[4:0]}; pattern is right-aligned, MSB-first, 1 = dash.
    localparam logic [7:0] MORSE_TABLE [0:NUM_LETTERS+NUM_DIGITS-1] = '{
        {3'd2, 5'b00001},  // A .-
        {3'd4, 5'b01000},  // B -...
        {3'd4, 5'b01010},  // C -.-.
        {3'd3, 5'b00100},  // D -..
        {3'd1, 5'b00000},  // E .
        {3'd4, 5'b00010},  // F ..-.
        {3'd3, 5'b00110},  // G --.
        {3'd4, 5'b00000},  // H ....
        {3'd2, 5'b00000},  // I ..
        {3'd4, 5'b00111},  // J .---
        {3'd3, 5'b00101},  // K -.-
        {3'd4, 5'b00100},  // L .-..
        {3'd2, 5'b00011},  // M --
        {3'd2, 5'b00010},  // N -.
        {3'd3, 5'b00111},  // O ---
        {3'd4, 5'b00110},  // P .--.
        {3'd4, 5'b01101},  // Q --.-
        {3'd3, 5'b00010},  // R .-.
        {3'd3, 5'b00000},  // S ...
        {3'd1, 5'b00001},  // T -
        {3'd3, 5'b00001},  // U ..-
        {3'd4, 5'b00001},  // V ...-
        {3'd3, 5'b00011},  // W .--
        {3'd4, 5'b01001},  // X -..-
        {3'd4, 5'b01011},  // Y -.--
        {3'd4, 5'b01100},  // Z --..
        {3'd5, 5'b11111},  // 0
        {3'd5, 5'b01111},  // 1
        {3'd5, 5'b00111},  // 2
        {3'd5, 5'b00011},  // 3
        {3'd5, 5'b00001},  // 4
        {3'd5, 5'b00000},  // 5
        {3'd5, 5'b10000},  // 6
        {3'd5, 5'b11000},  // 7
        {3'd5, 5'b11100},  // 8
        {3'd5, 5'b11110}   // 9
    };

endpackage

// File: rtl/morse_encoder_if.sv
// Symbol handshake and Morse line outputs of morse_encoder.
interface morse_encoder_if #(
    parameter int CODE_W = 6
);
    logic              sym_valid;
    logic [CODE_W-1:0] sym_code;
    logic              sym_ready;
    logic              abort;
    logic              led_out;
    logic              busy;
    logic              err;

    modport master (
        output sym_valid, sym_code, abort,
        input  sym_ready, led_out, busy, err
    );

    modport slave (
        input  sym_valid, sym_code, abort,
        output sym_ready, led_out, busy, err
    );
endinterface

// File: rtl/morse_rom.sv
// Combinational symbol code -> {valid, len, pattern} lookup.
// Codes 26-35 (digits) are only valid when MORSE_DIGITS_EN is defined.
module morse_rom
    import morse_pkg::*;
#(
    parameter int CODE_W = 6
) (
    input  logic [CODE_W-1:0] i_code,
    output logic              o_valid,
    output logic [2:0]        o_len,
    output logic [PAT_W-1:0]  o_pattern
);

    logic [7:0] w_entry;
    logic       w_found;

    always_comb begin
        w_entry = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_LETTERS + NUM_DIGITS; i++) begin
            if (int'(i_code) == i) begin
                w_entry = MORSE_TABLE[i];
                w_found = 1'b1;
            end
        end
        o_len = w_entry[7:5];
`ifdef MORSE_DIGITS_EN
        o_valid   = w_found;
        o_pattern = w_entry[4:0];
`else
        // Letters never use pattern bit 4; a set bit would mean a 5-element code.
        o_valid   = w_found && (int'(i_code) < NUM_LETTERS) && !w_entry[4];
        o_pattern = w_entry[3:0];
`endif
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: one symbol per handshake, unit-timed mark/gap/tail on led_out.
// Digits 0-9 are supported when MORSE_DIGITS_EN is defined.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int DOT_CYCLES       = 25000000,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int CODE_W           = 6
) (
    input  logic            clock,
    input  logic            reset,
    morse_encoder_if.slave  bus
);

    localparam int LONGEST = (LETTER_GAP_UNITS * DOT_CYCLES > DOT_CYCLES) ?
                             LETTER_GAP_UNITS * DOT_CYCLES : DOT_CYCLES;
    localparam int CNT_W   = $clog2(3 * LONGEST + 1);

    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * DOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAIL_LOAD = CNT_W'(LETTER_GAP_UNITS * DOT_CYCLES - 1);

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [PAT_W-1:0]   r_pat, w_pat_n;
    logic [2:0]         r_rem, w_rem_n;
    logic               r_led, r_err, w_err_n;

    logic               w_rom_valid;
    logic [2:0]         w_rom_len;
    logic [PAT_W-1:0]   w_rom_pat;
    logic               w_hs;

    morse_rom #(.CODE_W(CODE_W)) u_rom (
        .i_code    (bus.sym_code),
        .o_valid   (w_rom_valid),
        .o_len     (w_rom_len),
        .o_pattern (w_rom_pat)
    );

    assign bus.sym_ready = (r_state == IDLE) && reset;
    assign w_hs          = bus.sym_valid && bus.sym_ready;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_pat_n   = r_pat;
        w_rem_n   = r_rem;
        w_err_n   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (w_rom_valid) begin
                        // Left-align so the current element is always the MSB.
                        w_pat_n   = w_rom_pat << (3'(PAT_W) - w_rom_len);
                        w_rem_n   = w_rom_len - 3'd1;
                        w_cnt_n   = w_pat_n[PAT_W-1] ? DASH_LOAD : DOT_LOAD;
                        w_state_n = MARK;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            MARK: begin
                if (r_cnt == '0) begin
                    if (r_rem != 3'd0) begin
                        w_state_n = GAP;
                        w_cnt_n   = DOT_LOAD;
                    end else begin
                        w_state_n = TAIL;
                        w_cnt_n   = TAIL_LOAD;
                    end
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_pat_n   = r_pat << 1;
                    w_rem_n   = r_rem - 3'd1;
                    w_cnt_n   = w_pat_n[PAT_W-1] ? DASH_LOAD : DOT_LOAD;
                    w_state_n = MARK;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            TAIL: begin
                if (r_cnt == '0) begin
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase
        if (bus.abort && (r_state != IDLE)) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_rem_n   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_rem   <= '0;
            r_led   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_pat   <= w_pat_n;
            r_rem   <= w_rem_n;
            r_led   <= (w_state_n == MARK);
            r_err   <= w_err_n;
        end
    end

    assign bus.led_out = r_led;
    assign bus.busy    = (r_state != IDLE);
    assign bus.err     = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Randomised and directed bench for morse_encoder (DOT_CYCLES=4, LETTER_GAP_UNITS=3).
module tb_morse_encoder;

    localparam int DOT = 4;
    localparam int LGU = 3;
`ifdef MORSE_DIGITS_EN
    localparam int NVALID = 36;
`else
    localparam int NVALID = 26;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    bit   exp_q[$];

    string MORSE_STR [0:35] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    always #5 clock = ~clock;

    morse_encoder_if #(.CODE_W(6)) bus ();

    morse_encoder #(
        .DOT_CYCLES       (DOT),
        .LETTER_GAP_UNITS (LGU),
        .CODE_W           (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Expected led_out per cycle after the handshake, from the Morse string.
    task automatic build_expected(input int code);
        string m;
        byte   c;
        exp_q.delete();
        m = MORSE_STR[code];
        for (int j = 0; j < m.len(); j++) begin
            c = m[j];
            repeat ((c == "-" ? 3 : 1) * DOT) exp_q.push_back(1'b1);
            if (j < m.len() - 1) repeat (DOT) exp_q.push_back(1'b0);
        end
        repeat (LGU * DOT) exp_q.push_back(1'b0);
    endtask

    task automatic test_symbol(input int code, input string tag);
        int n = 0;
        @(negedge clock);
        while (bus.sym_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 200) begin
            fails++;
            $display("FAIL %s ready_wait: sym_ready=%b required 1", tag, bus.sym_ready);
        end
        bus.sym_valid = 1'b1;
        bus.sym_code  = 6'(code);
        @(posedge clock);
        #1;
        bus.sym_valid = 1'b0;
        bus.sym_code  = 6'($urandom);
        if (code < NVALID) begin
            build_expected(code);
            foreach (exp_q[i]) begin
                @(negedge clock);
                checks++;
                if (bus.led_out !== exp_q[i] || bus.busy !== 1'b1 ||
                    bus.sym_ready !== 1'b0 || bus.err !== 1'b0) begin
                    fails++;
                    $display("FAIL %s code %0d cycle %0d: led,busy,ready,err=%b%b%b%b required %b100",
                             tag, code, i + 1, bus.led_out, bus.busy, bus.sym_ready, bus.err, exp_q[i]);
                end
            end
            @(negedge clock);
            checks++;
            if (bus.led_out !== 1'b0 || bus.busy !== 1'b0 || bus.sym_ready !== 1'b1) begin
                fails++;
                $display("FAIL %s code %0d end: led,busy,ready=%b%b%b required 001",
                         tag, code, bus.led_out, bus.busy, bus.sym_ready);
            end
        end else begin
            @(negedge clock);
            checks++;
            if (bus.err !== 1'b1 || bus.led_out !== 1'b0 || bus.sym_ready !== 1'b1 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL %s code %0d err_pulse: err,led,ready,busy=%b%b%b%b required 1010",
                         tag, code, bus.err, bus.led_out, bus.sym_ready, bus.busy);
            end
            @(negedge clock);
            checks++;
            if (bus.err !== 1'b0 || bus.led_out !== 1'b0 || bus.sym_ready !== 1'b1) begin
                fails++;
                $display("FAIL %s code %0d err_end: err,led,ready=%b%b%b required 001",
                         tag, code, bus.err, bus.led_out, bus.sym_ready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.led_out !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.sym_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: led,busy,err,ready=%b%b%b%b required 0000",
                     bus.led_out, bus.busy, bus.err, bus.sym_ready);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.sym_ready !== 1'b1 || bus.led_out !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready,led,busy=%b%b%b required 100",
                     bus.sym_ready, bus.led_out, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        bus.sym_valid = 1'b1;
        bus.sym_code  = 6'd19;
        @(posedge clock);
        #1;
        bus.sym_code = 6'd4;
        build_expected(19);
        foreach (exp_q[i]) begin
            @(negedge clock);
            checks++;
            if (bus.led_out !== exp_q[i] || bus.sym_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_T cycle %0d: led,ready=%b%b required %b0",
                         i + 1, bus.led_out, bus.sym_ready, exp_q[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (bus.sym_ready !== 1'b1 || bus.led_out !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready: ready,led=%b%b required 10", bus.sym_ready, bus.led_out);
        end
        @(posedge clock);
        #1;
        bus.sym_valid = 1'b0;
        build_expected(4);
        foreach (exp_q[i]) begin
            @(negedge clock);
            checks++;
            if (bus.led_out !== exp_q[i] || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_E cycle %0d: led,busy=%b%b required %b1",
                         i + 1, bus.led_out, bus.busy, exp_q[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (bus.sym_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_end: ready=%b required 1", bus.sym_ready);
        end
    endtask

    // Start 'A' and cancel 6 cycles into its dash, via abort (use_reset=0) or reset.
    task automatic test_cancel(input bit use_reset);
        @(negedge clock);
        bus.sym_valid = 1'b1;
        bus.sym_code  = 6'd0;
        @(posedge clock);
        #1;
        bus.sym_valid = 1'b0;
        build_expected(0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            checks++;
            if (bus.led_out !== exp_q[i]) begin
                fails++;
                $display("FAIL cancel_pre cycle %0d: led=%b required %b", i + 1, bus.led_out, exp_q[i]);
            end
        end
        if (use_reset) reset = 1'b0;
        else           bus.abort = 1'b1;
        @(posedge clock);
        #1;
        bus.abort = 1'b0;
        @(negedge clock);
        checks++;
        if (use_reset) begin
            if (bus.led_out !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.sym_ready !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid: led,busy,err,ready=%b%b%b%b required 0000",
                         bus.led_out, bus.busy, bus.err, bus.sym_ready);
            end
            reset = 1'b1;
            @(negedge clock);
            checks++;
            if (bus.sym_ready !== 1'b1 || bus.led_out !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_release: ready,led,busy=%b%b%b required 100",
                         bus.sym_ready, bus.led_out, bus.busy);
            end
        end else begin
            if (bus.led_out !== 1'b0 || bus.sym_ready !== 1'b1 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL abort: led,ready,busy=%b%b%b required 010",
                         bus.led_out, bus.sym_ready, bus.busy);
            end
            @(negedge clock);
            checks++;
            if (bus.led_out !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_hold: led,busy=%b%b required 00", bus.led_out, bus.busy);
            end
        end
    endtask

    task automatic test_all_codes();
        for (int c = 0; c < 36; c++) test_symbol(c, "table");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) test_symbol(int'($urandom_range(0, 45)), "random");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.sym_valid = 1'b0;
        bus.sym_code  = '0;
        bus.abort     = 1'b0;
        test_reset();
        test_symbol(0, "letter_A");
        test_symbol(4, "letter_E");
        test_back_to_back();
        test_symbol(40, "invalid_40");
        test_cancel(1'b0);
        test_cancel(1'b1);
        test_symbol(26, "digit_0");
        test_all_codes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
